// File: rtl/array_burst_reader_if.sv
// rtl/array_burst_reader_if.sv - command, array read and output stream bundle for the burst reader
interface array_burst_reader_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 2
);
    // burst command and status
    logic             start;
    logic [ADDR-1:0]  start_addr;
    logic [ADDR:0]    burst_len;
    logic             busy;
    logic             done;

    // combinational-read array port
    logic [ADDR-1:0]  mem_read_addr;
    logic [WIDTH-1:0] mem_read_data;

    // output word stream
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    // the reader: takes commands, drives the array address, produces the stream
    modport master (
        input  start,
        input  start_addr,
        input  burst_len,
        output busy,
        output done,
        output mem_read_addr,
        input  mem_read_data,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last
    );

    // the surroundings: command source, the array and the stream consumer
    modport slave (
        output start,
        output start_addr,
        output burst_len,
        input  busy,
        input  done,
        input  mem_read_addr,
        output mem_read_data,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last
    );
endinterface

// File: rtl/array_burst_reader.sv
// rtl/array_burst_reader.sv - walks a contiguous array range and streams the words out
module array_burst_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    array_burst_reader_if.master bus
);
    localparam int ADDR = $clog2(DEPTH);

    localparam logic [ADDR:0]   DEPTH_W   = (ADDR + 1)'(DEPTH);
    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
    localparam logic [ADDR:0]   ONE_LEFT  = (ADDR + 1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR-1:0]  read_addr;
    logic [ADDR:0]    remaining;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             last_q;

    logic             latch_cmd;
    logic             load_beat;
    logic             clear_beat;
    logic             slot_free;
    logic [ADDR:0]    len_clamped;
    logic [ADDR-1:0]  addr_first;
    logic [ADDR-1:0]  addr_step;

    // Oversized lengths collapse to one full pass of the array; start addresses
    // past the end (only possible for non-power-of-two DEPTH) fall back to word 0.
    assign len_clamped = (bus.burst_len > DEPTH_W) ? DEPTH_W : bus.burst_len;
    assign addr_first  = ({1'b0, bus.start_addr} >= DEPTH_W) ? '0 : bus.start_addr;
    assign addr_step   = (read_addr == LAST_ADDR) ? '0 : read_addr + 1'b1;

    // The output stage can take a new word when empty or when its word leaves this cycle.
    assign slot_free = !valid_q || bus.out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_next = state;
        latch_cmd  = 1'b0;
        load_beat  = 1'b0;
        clear_beat = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    latch_cmd  = 1'b1;
                    state_next = (len_clamped != '0) ? READ : FINISH;
                end
            end
            READ: begin
                if (slot_free) begin
                    load_beat = 1'b1;
                    if (remaining == ONE_LEFT) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last beat sits in the output stage until the consumer takes it,
                // so the next burst can never load in the same cycle.
                if (bus.out_ready) begin
                    clear_beat = 1'b1;
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address walker, remaining count and the single output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_addr <= '0;
            remaining <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            if (latch_cmd) begin
                read_addr <= addr_first;
                remaining <= len_clamped;
            end
            if (load_beat) begin
                data_q    <= bus.mem_read_data;
                valid_q   <= 1'b1;
                last_q    <= (remaining == ONE_LEFT);
                read_addr <= addr_step;
                remaining <= remaining - 1'b1;
            end else if (clear_beat) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == FINISH);
    assign bus.mem_read_addr = read_addr;
    assign bus.out_data      = data_q;
    assign bus.out_valid     = valid_q;
    assign bus.out_last      = last_q;

endmodule

// File: tb/tb_array_burst_reader.sv
// tb/tb_array_burst_reader.sv - directed scoreboard bench for array_burst_reader
module tb_array_burst_reader;
    logic clk;
    logic rst;
    int   cyc;
    int   n_assert;
    int   n_fail;
    int   n_done;
    int   n_acc;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] mem [0:3];

    array_burst_reader_if #(.WIDTH(8), .ADDR(2)) bus ();

    array_burst_reader #(.WIDTH(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.mem_read_data = mem[bus.mem_read_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] word_at(input int a);
        return 8'(a * 8'h22);
    endfunction

    // expected word sequence for a burst, with wrap and length clamp
    task automatic push_burst(input int addr, input int len);
        int n;
        int a;
        n = (len > 4) ? 4 : len;
        a = addr;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({word_at(a), (i == n - 1)});
            a = (a == 3) ? 0 : a + 1;
        end
    endtask

    // stream monitor: scoreboard pop on handshake, backpressure stability
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [1:0] prev_addr;
    beat_t      got;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                chk("hold_data", {24'b0, bus.out_data}, {24'b0, prev_data});
                chk("hold_last", {31'b0, bus.out_last}, {31'b0, prev_last});
                chk("hold_addr", {30'b0, bus.mem_read_addr}, {30'b0, prev_addr});
            end
            if (bus.out_valid && bus.out_ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {24'b0, bus.out_data}, 32'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    chk("beat_data", {24'b0, bus.out_data}, {24'b0, got.d});
                    chk("beat_last", {31'b0, bus.out_last}, {31'b0, got.l});
                end
            end
            if (bus.done) n_done++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            prev_addr  = bus.mem_read_addr;
        end
    end

    task automatic start_burst(input int addr, input int len, output int sc);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.start_addr = 2'(addr);
        bus.burst_len  = 3'(len);
        push_burst(addr, len);
        @(posedge clk);
        #1;
        sc        = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int dc);
        bit found;
        found = 1'b0;
        dc    = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                found = 1'b1;
                dc    = cyc;
                break;
            end
        end
        if (!found) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    int sc;
    int dc;
    int done_before;
    bit [6:0] rdy_pat;

    initial begin
        cyc            = 0;
        n_assert       = 0;
        n_fail         = 0;
        n_done         = 0;
        n_acc          = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.burst_len  = '0;
        bus.out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) mem[i] = 8'(i * 8'h22);

        // reset state
        @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_last", {31'b0, bus.out_last}, 32'd0);
        chk("rst_data", {24'b0, bus.out_data}, 32'd0);
        chk("rst_addr", {30'b0, bus.mem_read_addr}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: full burst from 0, full throughput
        done_before = n_done;
        start_burst(0, 4, sc);
        chk("t1_busy_after_start", {31'b0, bus.busy}, 32'd1);
        chk("t1_no_valid_yet", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("t1_first_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("t1_first_data", {24'b0, bus.out_data}, 32'h00);
        wait_done("t1", dc);
        chk("t1_done_latency", 32'(dc - sc), 32'd5);
        @(posedge clk);
        #1;
        chk("t1_busy_low", {31'b0, bus.busy}, 32'd0);
        chk("t1_done_low", {31'b0, bus.done}, 32'd0);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_done_count", 32'(n_done - done_before), 32'd1);

        // 2: wrap from address 2
        start_burst(2, 4, sc);
        wait_done("t2", dc);
        chk("t2_done_latency", 32'(dc - sc), 32'd5);
        @(posedge clk);
        #1;
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: backpressure pattern 1,0,0,1,0,1,1
        rdy_pat = 7'b1101001;
        start_burst(0, 4, sc);
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = rdy_pat[i];
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        wait_done("t3", dc);
        @(posedge clk);
        #1;
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t3_busy_low", {31'b0, bus.busy}, 32'd0);

        // 4a: zero-length burst
        done_before = n_done;
        start_burst(0, 0, sc);
        chk("t4_busy_one", {31'b0, bus.busy}, 32'd1);
        chk("t4_done_now", {31'b0, bus.done}, 32'd1);
        @(posedge clk);
        #1;
        chk("t4_busy_gone", {31'b0, bus.busy}, 32'd0);
        chk("t4_done_gone", {31'b0, bus.done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_no_valid", {31'b0, bus.out_valid}, 32'd0);
        end
        chk("t4_done_count", 32'(n_done - done_before), 32'd1);

        // 4b: length 7 clamps to a full pass
        start_burst(0, 7, sc);
        wait_done("t4b", dc);
        chk("t4b_done_latency", 32'(dc - sc), 32'd5);
        @(posedge clk);
        #1;
        chk("t4b_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: start while busy is ignored
        done_before = n_done;
        start_burst(1, 4, sc);
        bus.start      = 1'b1;
        bus.start_addr = 2'd3;
        bus.burst_len  = 3'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("t5", dc);
        chk("t5_done_latency", 32'(dc - sc), 32'd5);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t5_done_count", 32'(n_done - done_before), 32'd1);

        // 6: asynchronous reset after the second accepted beat
        n_acc = 0;
        start_burst(0, 4, sc);
        for (int i = 0; i < 20; i++) begin
            if (n_acc >= 2) break;
            @(posedge clk);
            #2;
        end
        chk("t6_two_accepted", 32'(n_acc), 32'd2);
        done_before = n_done;
        rst = 1'b1;
        #1;
        chk("t6_valid_drop", {31'b0, bus.out_valid}, 32'd0);
        chk("t6_busy_drop", {31'b0, bus.busy}, 32'd0);
        chk("t6_done_drop", {31'b0, bus.done}, 32'd0);
        chk("t6_last_drop", {31'b0, bus.out_last}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_beat_after_rst", {31'b0, bus.out_valid}, 32'd0);
        end
        chk("t6_no_done", 32'(n_done - done_before), 32'd0);
        start_burst(0, 2, sc);
        wait_done("t6b", dc);
        chk("t6b_done_latency", 32'(dc - sc), 32'd3);
        @(posedge clk);
        #1;
        chk("t6b_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t6b_busy_low", {31'b0, bus.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
